// File: rtl/otter_regfile_mp.sv
// Multi-read-port OTTER register file with per-register busy scoreboard and a
// counter-driven clear after reset. Optional write-through forwarding: RF_BYPASS_EN.

module otter_regfile_rdport #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int ABW   = 5
) (
   input  logic                        run,
   input  logic [ABW-1:0]              addr,
   input  logic [NREGS-1:0][XLEN-1:0]  rf,
   input  logic [NREGS-1:0]            busy,
   input  logic                        fwd,
   input  logic [ABW-1:0]              wr_addr,
   input  logic [XLEN-1:0]             wr_data,
   output logic [XLEN-1:0]             data,
   output logic                        bsy
);
   logic hit;
   assign hit = run && (addr != '0) && (32'(addr) < 32'(NREGS));

   always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (hit) begin
         // forwarded write wins over the stored value and its busy bit
         if (fwd && (addr == wr_addr)) begin
            data = wr_data;
         end else begin
            data = rf[addr];
            bsy  = busy[addr];
         end
      end
   end
endmodule

module otter_regfile_mp #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   localparam int ABW   = $clog2(NREGS)
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  ready,
   input  logic [NRD*ABW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [ABW-1:0]        wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  iss_en,
   input  logic [ABW-1:0]        iss_addr
);
   typedef enum logic {CLEAR, RUN} state_t;

   state_t                       state;
   logic [ABW-1:0]               cnt;
   logic [NREGS-1:0][XLEN-1:0]   rf;
   logic [NREGS-1:0]             busy;
   logic [NRD-1:0][XLEN-1:0]     rdat;
   logic                         run, wr_ok, iss_ok, fwd;

   assign run    = (state == RUN);
   assign wr_ok  = run && wr_en  && (wr_addr  != '0) && (32'(wr_addr)  < 32'(NREGS));
   assign iss_ok = run && iss_en && (iss_addr != '0) && (32'(iss_addr) < 32'(NREGS));

`ifdef RF_BYPASS_EN
   assign fwd = wr_ok;
`else
   assign fwd = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
         busy  <= '0;
      end else begin
         case (state)
            CLEAR: begin
               rf[cnt]   <= '0;
               busy[cnt] <= 1'b0;
               cnt       <= cnt + 1'b1;
               if (cnt == ABW'(NREGS-1)) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (wr_ok) begin
                  rf[wr_addr]   <= wr_data;
                  busy[wr_addr] <= 1'b0;
               end
               // issue after writeback so a same-edge pair leaves the reg busy
               if (iss_ok) busy[iss_addr] <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      otter_regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .ABW(ABW)) u_rd (
         .run     (run),
         .addr    (rd_addr[i*ABW +: ABW]),
         .rf      (rf),
         .busy    (busy),
         .fwd     (fwd),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .data    (rdat[i]),
         .bsy     (rd_busy[i])
      );
   end

   assign rd_data = rdat;
endmodule

// File: tb/tb_otter_regfile_mp.sv
// Scoreboard bench for otter_regfile_mp: expected reads queued at drive time,
// popped and compared at the following falling edge.

module tb_otter_regfile_mp;
   localparam int XLEN = 32, NREGS = 32, NRD = 2, ABW = 5;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 ready;
   logic [NRD*ABW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 wr_en;
   logic [ABW-1:0]       wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 iss_en;
   logic [ABW-1:0]       iss_addr;

   otter_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clock(clock), .reset(reset), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr)
   );

   always #5 clock = ~clock;

   typedef struct {
      string            tag;
      int               port;
      logic [XLEN-1:0]  data;
      logic             busy;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input int port, input logic [ABW-1:0] a);
      rd_addr[port*ABW +: ABW] = a;
   endtask

   task automatic sb(input string tag, input int port, input logic [XLEN-1:0] d, input logic b);
      exp_t e;
      e.tag = tag; e.port = port; e.data = d; e.busy = b;
      sbq.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      @(negedge clock);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({e.tag, ".data"}, rd_data[e.port*XLEN +: XLEN], e.data);
         chk({e.tag, ".busy"}, {31'b0, rd_busy[e.port]}, {31'b0, e.busy});
      end
   endtask

   task automatic wr(input logic [ABW-1:0] a, input logic [XLEN-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic iss(input logic [ABW-1:0] a);
      iss_en = 1'b1; iss_addr = a;
      cyc();
      iss_en = 1'b0;
   endtask

   // clear window: ready low after edges 1..31, high after edge 32
   task automatic clear_window(input string tag);
      for (int e = 1; e <= 32; e++) begin
         cyc();
         chk($sformatf("%s.ready%0d", tag, e), {31'b0, ready}, (e == 32) ? 32'd1 : 32'd0);
         if (e < 32 && (e % 8 == 1 || e == 31)) begin
            sb($sformatf("%s.clr%0d.p0", tag, e), 0, '0, 1'b0);
            sb($sformatf("%s.clr%0d.p1", tag, e), 1, '0, 1'b0);
            check_now();
         end
         if (e == 31) begin
            wr_en = 1'b0; iss_en = 1'b0;
         end
      end
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;

      cyc();
      chk("rst.ready", {31'b0, ready}, 32'd0);
      reset = 1'b0;
      // writes/issues during CLEAR must be ignored
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_addr = 5'd4;
      rd(0, 5'd3); rd(1, 5'd4);
      clear_window("boot");
      sb("boot.x3", 0, '0, 1'b0);
      sb("boot.x4", 1, '0, 1'b0);
      check_now();

      wr(5'd5, 32'hDEAD_BEEF);
      rd(0, 5'd5); rd(1, 5'd5);
      sb("x5.p0", 0, 32'hDEAD_BEEF, 1'b0);
      sb("x5.p1", 1, 32'hDEAD_BEEF, 1'b0);
      check_now();

      wr(5'd0, 32'h0000_1234);
      iss(5'd0);
      rd(0, 5'd0); rd(1, 5'd0);
      sb("x0.p0", 0, '0, 1'b0);
      sb("x0.p1", 1, '0, 1'b0);
      check_now();

      iss(5'd7);
      rd(0, 5'd7); rd(1, 5'd5);
      sb("iss7", 0, '0, 1'b1);
      sb("iss7.other", 1, 32'hDEAD_BEEF, 1'b0);
      check_now();
      cyc(); cyc();
      sb("iss7.hold", 0, '0, 1'b1);
      check_now();
      wr(5'd7, 32'h0000_0055);
      sb("wr7", 0, 32'h0000_0055, 1'b0);
      check_now();
      iss_en = 1'b1; iss_addr = 5'd7;
      wr(5'd7, 32'h0000_0099);
      iss_en = 1'b0;
      sb("wriss7", 0, 32'h0000_0099, 1'b1);
      check_now();

      wr(5'd9, 32'h1111_1111);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
      iss_en = 1'b1; iss_addr = 5'd9;
      rd(0, 5'd9); rd(1, 5'd5);
`ifdef RF_BYPASS_EN
      sb("byp9.same", 0, 32'hA5A5_A5A5, 1'b0);
`else
      sb("byp9.same", 0, 32'h1111_1111, 1'b0);
`endif
      sb("byp9.other", 1, 32'hDEAD_BEEF, 1'b0);
      check_now();
      cyc();
      wr_en = 1'b0; iss_en = 1'b0;
      sb("byp9.next", 0, 32'hA5A5_A5A5, 1'b1);
      check_now();

      for (int i = 1; i < 32; i++) wr(ABW'(i), 32'h0101_0101 * i);
      iss(5'd12);
      rd(0, 5'd31); rd(1, 5'd12);
      sb("fill.x31", 0, 32'h0101_0101 * 31, 1'b0);
      sb("fill.x12", 1, 32'h0101_0101 * 12, 1'b1);
      check_now();

      // reset from RUN, then abort the clear at cnt==10
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         cyc();
         chk($sformatf("abort.ready%0d", e), {31'b0, ready}, 32'd0);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      clear_window("reclr");
      for (int i = 1; i < 32; i += 2) begin
         rd(0, ABW'(i)); rd(1, ABW'(i + 1));
         sb($sformatf("zero.x%0d", i), 0, '0, 1'b0);
         sb($sformatf("zero.x%0d", (i + 1) % 32), 1, '0, 1'b0);
         check_now();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
